// File: rtl/vrf_wb_arbiter.sv
// Round-robin write-back arbiter: several vector units share one VRF write port
// through a registered one-entry output stage, with a commit pulse per accepted write.
module vrf_wb_arbiter #(
    parameter int NrReq = 3,
    parameter int DataW = 64,
    parameter int AddrW = 8,
    parameter int IdW   = 4,
    parameter int StrbW = DataW / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NrReq-1:0]            req_valid_i,
    output logic [NrReq-1:0]            req_gnt_o,
    input  logic [NrReq-1:0][DataW-1:0] req_wdata_i,
    input  logic [NrReq-1:0][StrbW-1:0] req_wstrb_i,
    input  logic [NrReq-1:0][AddrW-1:0] req_addr_i,
    input  logic [NrReq-1:0][IdW-1:0]   req_id_i,
    output logic                        vrf_wvalid_o,
    input  logic                        vrf_wready_i,
    output logic [DataW-1:0]            vrf_wdata_o,
    output logic [StrbW-1:0]            vrf_wstrb_o,
    output logic [AddrW-1:0]            vrf_waddr_o,
    output logic [IdW-1:0]              vrf_wid_o,
    output logic                        wb_commit_o,
    output logic [IdW-1:0]              wb_commit_id_o
);
    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
        logic [AddrW-1:0] addr;
        logic [IdW-1:0]   id;
    } wb_word_t;

    logic            out_valid_q;
    wb_word_t        out_q;
    logic [PtrW-1:0] rr_q;
    logic [PtrW-1:0] win;
    logic            any_gnt;
    logic            free;

    // Reset gates the stage so a discarded word is never written or committed.
    assign free = !rst_i && (!out_valid_q || vrf_wready_i);

    always_comb begin
        int idx;
        req_gnt_o = '0;
        win       = '0;
        any_gnt   = 1'b0;
        idx       = 0;
        if (free) begin
            for (int k = 0; k < NrReq; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NrReq) idx = idx - NrReq;
                if (!any_gnt && req_valid_i[idx]) begin
                    any_gnt        = 1'b1;
                    win            = PtrW'(idx);
                    req_gnt_o[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            rr_q        <= '0;
        end else if (any_gnt) begin
            out_valid_q <= 1'b1;
            out_q.data  <= req_wdata_i[win];
            out_q.strb  <= req_wstrb_i[win];
            out_q.addr  <= req_addr_i[win];
            out_q.id    <= req_id_i[win];
            rr_q        <= (win == PtrW'(NrReq - 1)) ? '0 : win + 1'b1;
        end else if (vrf_wready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign vrf_wvalid_o   = out_valid_q && !rst_i;
    assign vrf_wdata_o    = out_q.data;
    assign vrf_wstrb_o    = out_q.strb;
    assign vrf_waddr_o    = out_q.addr;
    assign vrf_wid_o      = out_q.id;
    assign wb_commit_o    = vrf_wvalid_o && vrf_wready_i;
    assign wb_commit_id_o = out_q.id;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed bench for vrf_wb_arbiter: reset, contention, streaming, backpressure,
// pointer wrap/skip and mid-operation reset.
module tb_vrf_wb_arbiter;
    localparam int NrReq = 3;
    localparam int DataW = 32;
    localparam int AddrW = 8;
    localparam int IdW   = 4;
    localparam int StrbW = DataW / 8;

    logic                        clk;
    logic                        rst;
    logic [NrReq-1:0]            valid;
    logic [NrReq-1:0]            gnt;
    logic [NrReq-1:0][DataW-1:0] wdata;
    logic [NrReq-1:0][StrbW-1:0] wstrb;
    logic [NrReq-1:0][AddrW-1:0] addr;
    logic [NrReq-1:0][IdW-1:0]   id;
    logic                        wvalid;
    logic                        wready;
    logic [DataW-1:0]            o_data;
    logic [StrbW-1:0]            o_strb;
    logic [AddrW-1:0]            o_addr;
    logic [IdW-1:0]              o_id;
    logic                        commit;
    logic [IdW-1:0]              commit_id;

    int n_cmp = 0;
    int n_err = 0;

    vrf_wb_arbiter #(.NrReq(NrReq), .DataW(DataW), .AddrW(AddrW), .IdW(IdW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_gnt_o(gnt),
        .req_wdata_i(wdata), .req_wstrb_i(wstrb), .req_addr_i(addr), .req_id_i(id),
        .vrf_wvalid_o(wvalid), .vrf_wready_i(wready),
        .vrf_wdata_o(o_data), .vrf_wstrb_o(o_strb), .vrf_waddr_o(o_addr), .vrf_wid_o(o_id),
        .wb_commit_o(commit), .wb_commit_id_o(commit_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DataW-1:0] mk_data(input int i, input logic [AddrW-1:0] a,
                                                 input logic [IdW-1:0] d);
        return {4'hD, 4'(i), 12'h000, d, a};
    endfunction

    task automatic set_req(input int i, input logic [AddrW-1:0] a, input logic [IdW-1:0] d);
        addr[i]  = a;
        id[i]    = d;
        wdata[i] = mk_data(i, a, d);
        wstrb[i] = 4'(1 << i);
    endtask

    initial begin
        rst    = 1'b1;
        valid  = '1;
        wready = 1'b1;
        for (int i = 0; i < NrReq; i++) set_req(i, 8'(8'h20 + i), 4'(i + 1));

        // Reset held with every requester valid
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); #1;
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_wvalid", 32'(wvalid), 32'h0);
            chk("rst_commit", 32'(commit), 32'h0);
        end

        // Contention after release: grants 0,1,2,0,1,2, commits 1,2,3,1,2,3
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            if (k == 6) valid = '0;
            #1;
            chk("cont_gnt", 32'(gnt), (k < 6) ? 32'(1 << (k % 3)) : 32'h0);
            if (k > 0) begin
                chk("cont_commit", 32'(commit), 32'h1);
                chk("cont_cid", 32'(commit_id), 32'(((k - 1) % 3) + 1));
            end else begin
                chk("cont_wvalid0", 32'(wvalid), 32'h0);
            end
        end

        // Single stream from requester 0, addresses 0x10..0x17
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            valid = (k < 8) ? 3'b001 : 3'b000;
            set_req(0, 8'(8'h10 + k), 4'(k));
            #1;
            chk("ss_gnt", 32'(gnt), (k < 8) ? 32'h1 : 32'h0);
            if (k > 0) begin
                chk("ss_wvalid", 32'(wvalid), 32'h1);
                chk("ss_addr", 32'(o_addr), 32'(8'h10 + k - 1));
                chk("ss_data", 32'(o_data), 32'(mk_data(0, 8'(8'h10 + k - 1), 4'(k - 1))));
                chk("ss_commit", 32'(commit), 32'h1);
                chk("ss_cid", 32'(commit_id), 32'(k - 1));
            end
        end
        @(negedge clk); #1;
        chk("ss_drained", 32'(wvalid), 32'h0);

        // Backpressure on requester 1
        valid = 3'b010;
        set_req(1, 8'h40, 4'h9);
        #1;
        chk("bp_gnt0", 32'(gnt), 32'h2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wready = 1'b0;
            set_req(1, 8'h41, 4'hA);
            #1;
            chk("bp_gnt", 32'(gnt), 32'h0);
            chk("bp_wvalid", 32'(wvalid), 32'h1);
            chk("bp_addr", 32'(o_addr), 32'h40);
            chk("bp_data", 32'(o_data), 32'(mk_data(1, 8'h40, 4'h9)));
            chk("bp_commit", 32'(commit), 32'h0);
        end
        @(negedge clk);
        wready = 1'b1;
        #1;
        chk("bp_gnt_rel", 32'(gnt), 32'h2);
        chk("bp_commit_rel", 32'(commit), 32'h1);
        chk("bp_cid_rel", 32'(commit_id), 32'h9);
        @(negedge clk);
        valid = '0;
        #1;
        chk("bp_addr2", 32'(o_addr), 32'h41);
        chk("bp_cid2", 32'(commit_id), 32'hA);
        chk("bp_gnt_idle", 32'(gnt), 32'h0);

        // Wrap and skip: pointer at 2, requesters 0 and 2 valid
        @(negedge clk);
        valid = 3'b101;
        set_req(0, 8'h50, 4'h5);
        set_req(2, 8'h52, 4'h7);
        #1;
        chk("wr_gnt2", 32'(gnt), 32'h4);
        chk("wr_wvalid", 32'(wvalid), 32'h0);
        @(negedge clk);
        valid = 3'b001;
        #1;
        chk("wr_gnt0", 32'(gnt), 32'h1);
        chk("wr_addr2", 32'(o_addr), 32'h52);
        chk("wr_cid2", 32'(commit_id), 32'h7);
        @(negedge clk);
        valid = 3'b111;
        #1;
        chk("wr_ptr1", 32'(gnt), 32'h2);
        chk("wr_addr0", 32'(o_addr), 32'h50);
        chk("wr_cid0", 32'(commit_id), 32'h5);

        // Reset while a word is stalled in the output stage
        @(negedge clk);
        valid  = '0;
        wready = 1'b0;
        #1;
        chk("mr_wvalid_pre", 32'(wvalid), 32'h1);
        chk("mr_addr_pre", 32'(o_addr), 32'h41);
        chk("mr_commit_pre", 32'(commit), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        wready = 1'b1;
        #1;
        chk("mr_wvalid", 32'(wvalid), 32'h0);
        chk("mr_commit", 32'(commit), 32'h0);
        @(negedge clk); #1;
        chk("mr_wvalid2", 32'(wvalid), 32'h0);
        chk("mr_commit2", 32'(commit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
